// File: rtl/arb_2_1_4b.sv
// Two-requester 4-bit arbiter with a registered output word and ready/valid handshake.
// Build option: define ARB_FIXED_PRIO_EN to make A always win contention (no round-robin).
module arb_2_1_4b #(
   parameter int STALL_MAX = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_a,
   input  logic [3:0] data_a,
   output logic       ack_a,
   input  logic       req_b,
   input  logic [3:0] data_b,
   output logic       ack_b,
   output logic       sel,
   output logic [3:0] z,
   output logic       z_valid,
   input  logic       z_ready,
   output logic       stall_err
);

   localparam int         DATA_W    = 4;
   localparam logic [7:0] STALL_LIM = 8'(STALL_MAX);

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t            state, state_nxt;
   logic              sel_nxt;
   logic [DATA_W-1:0] z_nxt;
   logic [7:0]        stall_cnt, stall_cnt_nxt;
   logic              stall_err_nxt;
   logic              grant_b;
   logic [DATA_W-1:0] mux_word;
   logic              xfer;

`ifndef ARB_FIXED_PRIO_EN
   logic              last_b, last_b_nxt;
`endif

   function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
      if (cnt >= STALL_LIM)
         sat_inc = STALL_LIM;
      else
         sat_inc = cnt + 8'd1;
   endfunction

   // Winner selection and 2:1 word mux feeding the capture register
   always_comb begin
`ifdef ARB_FIXED_PRIO_EN
      grant_b = req_b & ~req_a;
`else
      // Under contention the requester not granted last wins.
      grant_b = req_b & (~req_a | ~last_b);
`endif
      mux_word = grant_b ? data_b : data_a;
   end

   assign z_valid = (state == SEND);
   assign xfer    = (state == SEND) & z_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         sel       <= 1'b0;
         z         <= '0;
         stall_cnt <= 8'd0;
         stall_err <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
         last_b    <= 1'b1;
`endif
      end else begin
         state     <= state_nxt;
         sel       <= sel_nxt;
         z         <= z_nxt;
         stall_cnt <= stall_cnt_nxt;
         stall_err <= stall_err_nxt;
`ifndef ARB_FIXED_PRIO_EN
         last_b    <= last_b_nxt;
`endif
      end
   end

   // Next-state, capture and handshake outputs
   always_comb begin
      state_nxt     = state;
      sel_nxt       = sel;
      z_nxt         = z;
      stall_cnt_nxt = stall_cnt;
      stall_err_nxt = stall_err;
      ack_a         = 1'b0;
      ack_b         = 1'b0;
`ifndef ARB_FIXED_PRIO_EN
      last_b_nxt    = last_b;
`endif
      case (state)
         IDLE: begin
            if (req_a | req_b) begin
               state_nxt  = SEND;
               sel_nxt    = grant_b;
               z_nxt      = mux_word;
`ifndef ARB_FIXED_PRIO_EN
               // Pointer moves on capture so a stalled word does not starve the other side.
               last_b_nxt = grant_b;
`endif
            end
         end
         SEND: begin
            if (xfer) begin
               ack_a         = ~sel;
               ack_b         = sel;
               state_nxt     = IDLE;
               stall_cnt_nxt = 8'd0;
            end else begin
               stall_cnt_nxt = sat_inc(stall_cnt);
               if (stall_cnt_nxt == STALL_LIM)
                  stall_err_nxt = 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: doc/arb_2_1_4b.md
ARB_2_1_4B -- requirements
Module: arb_2_1_4b

Interface
REQ-001 Parameter: STALL_MAX, 16, number of consecutive stalled SEND cycles before stall_err sets; legal range 1..255.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req_a  input  1  requester A has a word pending; held until ack_a.
REQ-005 data_a  input  4  requester A word; stable while req_a is high.
REQ-006 ack_a  output  1  one-cycle pulse: A's word accepted downstream.
REQ-007 req_b  input  1  requester B has a word pending; held until ack_b.
REQ-008 data_b  input  4  requester B word; stable while req_b is high.
REQ-009 ack_b  output  1  one-cycle pulse: B's word accepted downstream.
REQ-010 sel  output  1  registered grant/mux select; 0 = A, 1 = B.
REQ-011 z  output  4  registered output word.
REQ-012 z_valid  output  1  z holds an untransferred word.
REQ-013 z_ready  input  1  downstream accepts z this cycle.
REQ-014 stall_err  output  1  sticky stall flag.

Function
REQ-015 The FSM SHALL have two states: IDLE (z_valid=0) and SEND (z_valid=1).
REQ-016 In IDLE, if req_a or req_b is high, the block SHALL pick a winner, register sel, capture the winner's data into z through an internal 2:1 4-bit mux, and enter SEND at the next edge.
REQ-017 If only one request is high, that requester SHALL win.
REQ-018 If both requests are high, the winner SHALL be the requester not granted last (round-robin); last-grant resets to B, so A wins the first contention.
REQ-019 In SEND, a transfer SHALL occur in any cycle where z_ready=1; that cycle ack_a=(sel==0) or ack_b=(sel==1) is high combinationally, and the FSM returns to IDLE at the next edge.
REQ-020 ack_a and ack_b SHALL never be high together and SHALL be low outside a transfer cycle.
REQ-021 After each transfer, one IDLE cycle is mandatory, giving a maximum throughput of one word per 2 cycles and an IDLE-with-request to z_valid latency of 1 cycle.
REQ-022 z and sel SHALL hold their values throughout SEND, regardless of req or data changes.
REQ-023 A req dropped during SEND SHALL NOT cancel the transfer; the latched word is still delivered.
REQ-024 The last-grant pointer SHALL update on capture, not on transfer.
REQ-025 An 8-bit stall counter SHALL increment each SEND cycle with z_ready=0, saturate at STALL_MAX, and clear on every transfer.
REQ-026 stall_err SHALL set when the counter reaches STALL_MAX and stay set until reset; arbitration continues normally.

Reset
REQ-027 Asserting rst SHALL asynchronously force: state=IDLE, z_valid=0, z=4'h0, sel=0, last-grant=B, stall counter=0, stall_err=0.
REQ-028 Reset mid-SEND SHALL discard the held word without an ack; after deassertion, the first edge with a request begins a fresh arbitration.

Configuration
REQ-029 Macro ARB_FIXED_PRIO_EN: when defined, A SHALL always win contention and the last-grant pointer is unused; when undefined, round-robin per REQ-018 applies.

Verification
REQ-030 Single A: req_a=1, data_a=4'h5, z_ready=1 -> next cycle z=4'h5, z_valid=1, sel=0, ack_a pulses 1 cycle, then IDLE.
REQ-031 Contention: req_a=req_b=1 held, data_a=4'h3, data_b=4'hC, z_ready=1 -> z sequence 3,C,3,C on alternate cycles; under ARB_FIXED_PRIO_EN -> 3,3,3,3.
REQ-032 Backpressure: capture 4'hA, z_ready=0 for 5 cycles, then 1 -> z stays 4'hA with z_valid=1, exactly one ack on the z_ready=1 cycle.
REQ-033 Stall: STALL_MAX=4, z_ready=0 in SEND -> stall_err=1 after 4 stalled cycles, remains 1 after subsequent transfers until rst.
REQ-034 Reset mid-SEND: word 4'h9 pending, rst pulsed -> z_valid=0, z=0, sel=0 immediately, no ack; with req_a and req_b both high afterwards, A wins first.
